pipe_reg_chain: RTL

- Parametrised, flow-controlled register pipeline: WIDTH-bit data delayed through DEPTH stages, each stage with its own valid bit.
- Generational successor to the team's single-bit D flip-flop.
- Adds valid/ready backpressure, bubble collapsing, synchronous flush and an occupancy count.
- Used as the generic retiming/delay element between datapath blocks.

---
 rtl/pipe_reg_pkg.sv | 23 ++
 rtl/pipe_reg_stage.sv | 59 +++++
 rtl/pipe_reg_chain.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pipe_reg_pkg.sv
// Shared definitions for the flow-controlled register pipeline.
// Optional feature macro: PIPE_REG_CHAIN_PARITY_EN (per-stage even-parity bit).
package pipe_reg_pkg;

    // Default geometry of a pipe_reg_chain instance.
    localparam int unsigned PIPE_REG_WIDTH_DEF = 8;
    localparam int unsigned PIPE_REG_DEPTH_DEF = 4;

    // Widest data word the parity helper accepts. Narrower words are
    // zero-extended before the call, which leaves the parity unchanged.
    localparam int unsigned PARITY_MAX_W = 256;

    // Bits needed to count 0..depth valid stages.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Even-parity bit: makes the total number of ones in {parity, data} even.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One stage of the register pipeline: a valid bit plus a data word.
// When the chain is built with PIPE_REG_CHAIN_PARITY_EN, the parity bit is
// carried inside the data word, so this stage is identical in both builds.
module pipe_reg_stage #(
    parameter int unsigned   W       = 8,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    input  logic         down_ready,
    output logic         valid,
    output logic         data_unused_guard,
    output logic [W-1:0] data,
    output logic         ready
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // An empty stage can always take a word; a full one only if it can pass
    // its own word on in the same cycle.
    assign ready = !valid_q || down_ready;

    assign valid             = valid_q;
    assign data              = data_q;
    assign data_unused_guard = 1'b0;

    // Next state: flush empties the stage but keeps its data; data is only
    // captured together with a valid word so it never moves under a bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (ready) begin
            valid_d = up_valid;
            if (up_valid) begin
                data_d = up_data;
            end
        end
    end

    // Stage registers; reset wins over flush and any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Flow-controlled register pipeline: WIDTH-bit words delayed through DEPTH
// stages with valid/ready backpressure, bubble collapsing, synchronous flush
// and a combinational occupancy count.
// Optional feature macro: PIPE_REG_CHAIN_PARITY_EN. When defined, every stage
// carries an even-parity bit generated at stage 0 and checked at the output;
// when undefined, parity_err and parity_err_sticky are tied low.
// The ready chain is combinational from out_ready back to in_ready so that a
// full chain keeps streaming at one word per cycle.
module pipe_reg_chain
    import pipe_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = PIPE_REG_WIDTH_DEF,
    parameter int unsigned      DEPTH     = PIPE_REG_DEPTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [occ_width(DEPTH)-1:0]  occupancy,
    output logic                         parity_err,
    output logic                         parity_err_sticky
);

    localparam int unsigned OW = occ_width(DEPTH);

`ifdef PIPE_REG_CHAIN_PARITY_EN
    // Stage word is {parity, data}.
    localparam int unsigned SW = WIDTH + 1;
    localparam logic [SW-1:0] STAGE_RST =
        {even_parity(PARITY_MAX_W'(RESET_VAL)), RESET_VAL};
`else
    localparam int unsigned SW = WIDTH;
    localparam logic [SW-1:0] STAGE_RST = RESET_VAL;
`endif

    logic [SW-1:0]    in_word;
    logic [DEPTH-1:0] up_v;
    logic [SW-1:0]    up_d [DEPTH];
    logic [DEPTH-1:0] v;
    logic [SW-1:0]    d    [DEPTH];
    logic [DEPTH-1:0] guard_unused;
    logic [DEPTH:0]   rdy;
    logic [OW-1:0]    occ_c;

`ifdef PIPE_REG_CHAIN_PARITY_EN
    assign in_word = {even_parity(PARITY_MAX_W'(in_data)), in_data};
`else
    assign in_word = in_data;
`endif

    assign rdy[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            // A word offered during flush is dropped, never captured.
            assign up_v[i] = in_valid && !flush;
            assign up_d[i] = in_word;
        end else begin : g_body
            assign up_v[i] = v[i-1];
            assign up_d[i] = d[i-1];
        end

        pipe_reg_stage #(
            .W       (SW),
            .RST_VAL (STAGE_RST)
        ) u_stage (
            .clk               (clk),
            .rst               (rst),
            .flush             (flush),
            .up_valid          (up_v[i]),
            .up_data           (up_d[i]),
            .down_ready        (rdy[i+1]),
            .valid             (v[i]),
            .data_unused_guard (guard_unused[i]),
            .data              (d[i]),
            .ready             (rdy[i])
        );
    end

    assign in_ready  = rdy[0] && !flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1][WIDTH-1:0];

    // Occupancy is the popcount of the stage valid bits.
    always_comb begin
        occ_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_c = occ_c + OW'(v[i]);
        end
    end

    assign occupancy = occ_c;

`ifdef PIPE_REG_CHAIN_PARITY_EN
    logic parity_err_c;
    logic sticky_q;
    logic sticky_d;

    assign parity_err_c = out_valid && ((^out_data) != d[DEPTH-1][WIDTH]);
    assign sticky_d     = sticky_q || parity_err_c;

    // Sticky error flag: once set, only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign parity_err        = parity_err_c;
    assign parity_err_sticky = sticky_q;
`else
    assign parity_err        = 1'b0;
    assign parity_err_sticky = 1'b0;
`endif

    // The guard outputs are constant zero; folding them into a signal that is
    // never consumed keeps the per-stage port list uniform.
    logic guard_or;
    assign guard_or = |guard_unused;

endmodule
